// File: rtl/divergence_scheduler_if.sv
// ---------------------------------------------------------------------------
// divergence_scheduler_if : fetch/update handshake of the SIMT divergence unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface divergence_scheduler_if #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
);
  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

  logic                                 start;
  logic [TCW-1:0]                       thread_count;
  logic                                 update;
  logic                                 ret;
  logic [THREADS_PER_BLOCK*PC_BITS-1:0] next_pc;
  logic [PC_BITS-1:0]                   current_pc;
  logic [THREADS_PER_BLOCK-1:0]         active_mask;
  logic                                 pc_valid;
  logic                                 diverged;
  logic                                 done;

  modport master (
    output start, thread_count, update, ret, next_pc,
    input  current_pc, active_mask, pc_valid, diverged, done
  );

  modport slave (
    input  start, thread_count, update, ret, next_pc,
    output current_pc, active_mask, pc_valid, diverged, done
  );
endinterface

`default_nettype wire

// File: rtl/divergence_scheduler.sv
// ---------------------------------------------------------------------------
// divergence_scheduler : per-thread PCs, min-PC fetch selection, active mask
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module divergence_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  divergence_scheduler_if.slave   bus
);
  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_READY  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [PC_BITS-1:0]           pc_q [THREADS_PER_BLOCK];
  logic [PC_BITS-1:0]           pc_d [THREADS_PER_BLOCK];
  logic [THREADS_PER_BLOCK-1:0] live_q, live_d;
  logic [PC_BITS-1:0]           cur_pc_q, cur_pc_d;
  logic [THREADS_PER_BLOCK-1:0] mask_q, mask_d;
  logic [PC_BITS-1:0]           w_min;
  logic [TCW-1:0]               w_tc;

  assign w_tc = (bus.thread_count > TCW'(THREADS_PER_BLOCK)) ? TCW'(THREADS_PER_BLOCK)
                                                             : bus.thread_count;

  always_comb begin
    w_min = '1;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (live_q[i] && (pc_q[i] < w_min)) w_min = pc_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    live_d   = live_q;
    cur_pc_d = cur_pc_q;
    mask_d   = mask_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            pc_d[i]   = '0;
            live_d[i] = (TCW'(i) < w_tc);
          end
          state_d = (w_tc == '0) ? S_DONE : S_SELECT;
        end
      end
      S_SELECT: begin
        // every live thread tied at the minimum PC runs together
        cur_pc_d = w_min;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
          mask_d[i] = live_q[i] && (pc_q[i] == w_min);
        end
        state_d = S_READY;
      end
      S_READY: begin
        if (bus.update) begin
          for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (mask_q[i]) begin
              if (bus.ret) live_d[i] = 1'b0;
              else         pc_d[i]   = bus.next_pc[i*PC_BITS +: PC_BITS];
            end
          end
          state_d = (live_d == '0) ? S_DONE : S_SELECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '{default: '0};
      live_q   <= '0;
      cur_pc_q <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      live_q   <= live_d;
      cur_pc_q <= cur_pc_d;
      mask_q   <= mask_d;
    end
  end

  assign bus.current_pc  = cur_pc_q;
  assign bus.active_mask = mask_q;
  assign bus.pc_valid    = (state_q == S_READY);
  assign bus.done        = (state_q == S_DONE);
  assign bus.diverged    = (state_q == S_READY) && (mask_q != live_q);

endmodule

`default_nettype wire

// File: tb/tb_divergence_scheduler.sv
// ---------------------------------------------------------------------------
// tb_divergence_scheduler : directed bench for divergence_scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_divergence_scheduler;
  localparam int T  = 4;
  localparam int PB = 8;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  divergence_scheduler_if #(.THREADS_PER_BLOCK(T), .PC_BITS(PB)) bus ();

  divergence_scheduler #(.THREADS_PER_BLOCK(T), .PC_BITS(PB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] pc, input logic [3:0] mask,
                         input logic valid, input logic div, input logic dn);
    chk({tag, ".pc"},    32'(bus.current_pc),  32'(pc));
    chk({tag, ".mask"},  32'(bus.active_mask), 32'(mask));
    chk({tag, ".valid"}, 32'(bus.pc_valid),    32'(valid));
    chk({tag, ".div"},   32'(bus.diverged),    32'(div));
    chk({tag, ".done"},  32'(bus.done),        32'(dn));
  endtask

  // Pulses start at a negedge; returns at the negedge where the DUT is in READY.
  task automatic do_start(input logic [2:0] tc);
    bus.start = 1'b1; bus.thread_count = tc;
    @(negedge clk);
    bus.start = 1'b0;
    chk("sel.valid", 32'(bus.pc_valid), 32'd0);
    @(negedge clk);
  endtask

  // Pulses update in READY; returns one cycle later (SELECT or DONE).
  task automatic do_update(input logic r, input logic [31:0] np);
    bus.update = 1'b1; bus.ret = r; bus.next_pc = np;
    @(negedge clk);
    bus.update = 1'b0; bus.ret = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.thread_count = '0; bus.update = 1'b0;
    bus.ret = 1'b0; bus.next_pc = '0;
    repeat (2) @(negedge clk);
    chk_out("reset", 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk_out("idle", 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // uniform flow
    do_start(3'd4);
    chk_out("u0", 8'd0, 4'b1111, 1'b1, 1'b0, 1'b0);
    do_update(1'b0, {4{8'd1}});
    chk("u0.sel", 32'(bus.pc_valid), 32'd0);
    @(negedge clk);
    chk_out("u1", 8'd1, 4'b1111, 1'b1, 1'b0, 1'b0);
    do_update(1'b0, {4{8'd2}}); @(negedge clk);
    chk_out("u2", 8'd2, 4'b1111, 1'b1, 1'b0, 1'b0);
    do_update(1'b0, {4{8'd3}}); @(negedge clk);
    chk_out("u3", 8'd3, 4'b1111, 1'b1, 1'b0, 1'b0);
    do_update(1'b1, '0);
    chk_out("u.ret", 8'd3, 4'b1111, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("u.hold", 32'(bus.done), 32'd1);

    // divergence and reconvergence
    do_start(3'd4);
    chk_out("d0", 8'd0, 4'b1111, 1'b1, 1'b0, 1'b0);
    do_update(1'b0, {8'd5, 8'd2, 8'd5, 8'd2}); @(negedge clk);
    chk_out("d.div", 8'd2, 4'b0101, 1'b1, 1'b1, 1'b0);
    do_update(1'b0, {4{8'd5}}); @(negedge clk);
    chk_out("d.reconv", 8'd5, 4'b1111, 1'b1, 1'b0, 1'b0);
    do_update(1'b1, '0);
    chk("d.done", 32'(bus.done), 32'd1);

    // partial retire
    do_start(3'd4);
    do_update(1'b0, {8'd5, 8'd2, 8'd5, 8'd2}); @(negedge clk);
    chk_out("p.div", 8'd2, 4'b0101, 1'b1, 1'b1, 1'b0);
    do_update(1'b1, '0);
    chk("p.done0", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk_out("p.rest", 8'd5, 4'b1010, 1'b1, 1'b0, 1'b0);
    do_update(1'b1, '0);
    chk("p.done1", 32'(bus.done), 32'd1);

    // thread_count=2 plus ignored events
    do_start(3'd2);
    chk_out("tc2", 8'd0, 4'b0011, 1'b1, 1'b0, 1'b0);
    do_update(1'b0, {8'd9, 8'd9, 8'd3, 8'd3});
    bus.update = 1'b1; bus.next_pc = {4{8'hAA}};
    @(negedge clk);
    bus.update = 1'b0;
    chk_out("tc2.upd_sel", 8'd3, 4'b0011, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b1; bus.thread_count = 3'd4;
    @(negedge clk);
    bus.start = 1'b0;
    chk_out("ign.start", 8'd3, 4'b0011, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b1;
    do_update(1'b0, {8'd7, 8'd7, 8'd4, 8'd4});
    bus.start = 1'b0;
    @(negedge clk);
    chk_out("ign.both", 8'd4, 4'b0011, 1'b1, 1'b0, 1'b0);
    do_update(1'b1, '0);
    chk("tc2.done", 32'(bus.done), 32'd1);

    // thread_count=0
    bus.start = 1'b1; bus.thread_count = 3'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("tc0.done", 32'(bus.done), 32'd1);
    chk("tc0.valid", 32'(bus.pc_valid), 32'd0);

    // thread_count=7 clamps, then asynchronous reset in READY at PC 5
    do_start(3'd7);
    chk_out("tc7", 8'd0, 4'b1111, 1'b1, 1'b0, 1'b0);
    do_update(1'b0, {4{8'd5}}); @(negedge clk);
    chk_out("pre.rst", 8'd5, 4'b1111, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 chk_out("async.rst", 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_start(3'd4);
    chk_out("restart", 8'd0, 4'b1111, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
